// File: rtl/pe_pkg.sv
// Shared definitions for the PE configuration sequencer: FSM encoding and
// kernel-size helpers used by the sequencer and its weight counter.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        CTRL   = 2'd2,
        GUARD  = 2'd3
    } pe_state_t;

    // Number of weights in one load for a square kernel.
    function automatic int k2_of(input int kernel);
        return kernel * kernel;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_cfg_seq_if.sv
// Weight-stream handshake between a weight source (master) and the
// PE configuration sequencer (slave).
interface pe_cfg_seq_if #(
    parameter int M = 4
);
    logic         wq_valid;
    logic [M-1:0] wq_data;
    logic         wq_ready;

    modport master (output wq_valid, output wq_data, input wq_ready);
    modport slave  (input wq_valid, input wq_data, output wq_ready);
endinterface

// File: rtl/pe_cfg_cnt.sv
// Modulo-K2 weight counter with synchronous clear, enable and a last-count
// flag; wraps to zero when enabled at the last count.
module pe_cfg_cnt
    import pe_pkg::*;
#(
    parameter int K2 = 9,
    parameter int W  = cnt_width(K2)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [W-1:0] count_reg;

    assign last = (count_reg == W'(K2 - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= last ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pe_cfg_seq.sv
// PE configuration sequencer: streams K2 weights to the PE, then one control
// strobe carrying the bypass setup, then a done pulse. Optional abort via
// macro PE_CFG_ABORT_EN.
module pe_cfg_seq
    import pe_pkg::*;
#(
    parameter int CL_IN  = 4,
    parameter int CL1    = 2,
    parameter int KERNEL = 3,
    parameter int M      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CL_IN-1:0] cfg_bp_ch,
    input  logic [CL1-1:0]   cfg_bp_src,
    pe_cfg_seq_if.slave      wq,
    output logic [M-1:0]     w_in,
    output logic             w_conf,
    output logic             cntl_conf,
    output logic [CL_IN-1:0] bp_ch_in,
    output logic [CL1-1:0]   bp_src_in,
    output logic             busy,
    output logic             done
`ifdef PE_CFG_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int K2 = k2_of(KERNEL);

    pe_state_t        state_reg, state_next;
    logic             ready_next;
    logic             accept;
    logic             capture;
    logic             abort_hit;
    logic             cnt_last;
    logic             cntl_next, done_next;

    logic [M-1:0]     w_in_reg;
    logic             w_conf_reg;
    logic             cntl_conf_reg;
    logic             done_reg;
    logic [CL_IN-1:0] bp_ch_reg;
    logic [CL1-1:0]   bp_src_reg;

    pe_cfg_cnt #(.K2(K2)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (capture),
        .en   (accept),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD_W;
            LOAD_W: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (accept && cnt_last) begin
                    state_next = CTRL;
                end
            end
            CTRL:    state_next = GUARD;
            GUARD:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and done are registered one cycle behind the state so the
    // final weight strobe and the control strobe can never share a cycle.
    always_comb begin
        capture   = (state_reg == IDLE) && start;
        cntl_next = (state_reg == CTRL);
        done_next = (state_reg == GUARD);
        busy      = (state_reg != IDLE);
`ifdef PE_CFG_ABORT_EN
        abort_hit  = (state_reg == LOAD_W) && abort;
`else
        abort_hit  = 1'b0;
`endif
        ready_next = (state_reg == LOAD_W) && !abort_hit;
        accept     = ready_next && wq.wq_valid;
    end

    assign wq.wq_ready = ready_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_in_reg      <= '0;
            w_conf_reg    <= 1'b0;
            cntl_conf_reg <= 1'b0;
            done_reg      <= 1'b0;
            bp_ch_reg     <= '0;
            bp_src_reg    <= '0;
        end else begin
            w_conf_reg    <= accept;
            cntl_conf_reg <= cntl_next;
            done_reg      <= done_next;
            if (accept) begin
                w_in_reg <= wq.wq_data;
            end
            if (capture) begin
                bp_ch_reg  <= cfg_bp_ch;
                bp_src_reg <= cfg_bp_src;
            end
        end
    end

`ifdef PE_CFG_ABORT_EN
    logic aborted_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aborted_reg <= 1'b0;
        end else begin
            aborted_reg <= abort_hit;
        end
    end

    assign aborted = aborted_reg;
`endif

    assign w_in      = w_in_reg;
    assign w_conf    = w_conf_reg;
    assign cntl_conf = cntl_conf_reg;
    assign done      = done_reg;
    assign bp_ch_in  = bp_ch_reg;
    assign bp_src_in = bp_src_reg;

endmodule

// File: doc/pe_cfg_seq.md
PE_CFG_SEQ -- requirements
Module: pe_cfg_seq

Interface
REQ-001 SHALL have parameter CL_IN, default 4: number of PE feature channels.
REQ-002 SHALL have parameter CL1, default 2: bypass-source bus width.
REQ-003 SHALL have parameter KERNEL, default 3: kernel side; K2 = KERNEL*KERNEL weights per load.
REQ-004 SHALL have parameter M, default 4: weight width (2's complement).
REQ-005 SHALL have ports clk input 1 (single clock) and rst input 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports start input 1 (request one configuration load) and cfg_bp_ch input CL_IN (bypass channel mask for the load).
REQ-007 SHALL have ports cfg_bp_src input CL1 (bypass source for the load) and wq_valid input 1 (weight stream valid).
REQ-008 SHALL have ports wq_data input M (weight value) and wq_ready output 1 (weight stream ready).
REQ-009 SHALL have ports w_in output M and w_conf output 1 (weight value and its strobe, to PE).
REQ-010 SHALL have ports cntl_conf output 1 (PE control strobe), bp_ch_in output CL_IN and bp_src_in output CL1 (to PE).
REQ-011 SHALL have ports busy output 1 (load in progress) and done output 1 (one-cycle completion pulse).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_W, CTRL, GUARD.
REQ-013 IDLE: start=1 SHALL capture cfg_bp_ch/cfg_bp_src into internal registers, clear the weight counter and go to LOAD_W; start in any other state SHALL be ignored.
REQ-014 wq_ready SHALL be 1 only in LOAD_W; a weight is accepted on a cycle where wq_valid&wq_ready.
REQ-015 On each accepted weight, the next cycle SHALL drive w_in=wq_data and w_conf=1 (registered, latency 1).
REQ-016 On cycles without acceptance, w_conf SHALL be 0 and w_in SHALL hold its last value (stall-tolerant; PE counts strobes, not cycles).
REQ-017 Weight counter SHALL count 0..K2-1; the accept at count K2-1 SHALL move to CTRL with no wrap back into LOAD_W.
REQ-018 CTRL SHALL last exactly one cycle, with cntl_conf=1 and bp_ch_in/bp_src_in = captured values; the last w_conf and cntl_conf SHALL never coincide.
REQ-019 bp_ch_in/bp_src_in SHALL keep the captured values until the next start.
REQ-020 GUARD SHALL last one cycle, assert done=1, then return to IDLE; start asserted during GUARD SHALL be ignored.
REQ-021 busy SHALL be 1 in LOAD_W, CTRL and GUARD, and 0 in IDLE.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE, counter=0, w_in=0, w_conf=0, cntl_conf=0, bp_ch_in=0, bp_src_in=0, wq_ready=0, busy=0, done=0.
REQ-023 Reset mid-load SHALL discard partial weights and produce no cntl_conf or done; the next start SHALL begin again at weight 0.

Configuration
REQ-024 Macro PE_CFG_ABORT_EN defined SHALL add input abort (1 bit) and output aborted (1 bit).
REQ-025 With PE_CFG_ABORT_EN, abort=1 in LOAD_W SHALL return to IDLE next cycle, pulse aborted=1 for one cycle, and emit no cntl_conf or done.
REQ-026 With PE_CFG_ABORT_EN, abort SHALL have no effect in IDLE, CTRL or GUARD.
REQ-027 Without PE_CFG_ABORT_EN, ports abort and aborted SHALL not exist and the load SHALL always run to completion.

Structure
REQ-028 Shared package pe_pkg SHALL hold the FSM state encoding and a K2 function/constant derived from KERNEL.
REQ-029 Weight counting SHALL be one sub-module, pe_cfg_cnt: modulo-K2 counter with clear, enable and a last-count flag.

Verification
REQ-030 Bench SHALL cover: start, cfg_bp_ch=4'b1001, cfg_bp_src=2'b01, 9 back-to-back weights 4'h7 -> w_conf=1 for 9 consecutive cycles with w_in=4'h7, then cntl_conf=1 for 1 cycle with bp_ch_in=4'b1001 and bp_src_in=2'b01, then done=1 next cycle.
REQ-031 Bench SHALL cover: weights 1..9 with wq_valid low on alternate cycles -> exactly 9 w_conf pulses carrying 1..9 in order, and w_in held between pulses.
REQ-032 Bench SHALL cover: start re-asserted during LOAD_W and during GUARD -> no restart, and bp_ch_in/bp_src_in unchanged.
REQ-033 Bench SHALL cover: rst=0 after 4 weights, then a full load of 9 weights 4'h3 -> exactly 9 strobes after reset, and no cntl_conf before the 9th.
REQ-034 Bench SHALL cover, with PE_CFG_ABORT_EN: abort after 5 weights -> aborted=1 for one cycle, busy=0 next cycle, no cntl_conf.
REQ-035 Bench SHALL cover: two back-to-back loads with different bp_ch values -> the second cntl_conf carries the second mask, and done is pulsed once per load.
